uart_tx_batcher: RTL and testbench
==================================

UART_TX_BATCHER -- requirements
Module: uart_tx_batcher

Interface
REQ-001 SHALL have parameter: N_TX_NUMS, default 1, number of 16-bit words per transfer; must match the downstream uart n_tx_nums.
REQ-002 SHALL have parameter: FIFO_DEPTH, default 16, word capacity of the internal buffer; a power of two and at least N_TX_NUMS.
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  in  1  producer has a word on in_num.
REQ-006 SHALL have port: in_num  in  16  signed word (num format) from producer.
REQ-007 SHALL have port: in_ready  out  1  buffer can accept a word this cycle.
REQ-008 SHALL have port: flush  in  1  single-cycle request to send a partial batch.
REQ-009 SHALL have port: tx_nums  out  N_TX_NUMS x 16  batch presented to uart.
REQ-010 SHALL have port: send_data  out  1  one-cycle start strobe to uart.
REQ-011 SHALL have port: tx_ready  in  1  uart transmitter idle.
REQ-012 SHALL have port: fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-013 SHALL have port: overflow  out  1  sticky flag for a dropped write.

Function
REQ-014 SHALL accept a word on each rising edge where in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready = (fifo_count < FIFO_DEPTH) combinationally from registered count.
REQ-016 SHALL drop the word and set overflow=1 when in_valid=1 and in_ready=0; overflow clears only on reset.
REQ-017 SHALL store words in FIFO order with wrap-around pointers, and support a simultaneous push and pop in the same cycle with fifo_count unchanged.
REQ-018 SHALL implement the FSM states IDLE, LOAD, SEND and WAIT.
REQ-019 IDLE SHALL go to LOAD when tx_ready=1 and either fifo_count>=N_TX_NUMS or a flush is pending with fifo_count>0; otherwise it SHALL stay in IDLE.
REQ-020 SHALL latch a flush pulse into flush_pending, clear it on entry to LOAD, and ignore it when fifo_count=0.
REQ-021 LOAD SHALL last exactly N_TX_NUMS cycles and, in cycle i, write tx_nums[i] from the FIFO head and pop it.
REQ-022 In a flushed LOAD with too few buffered words, tx_nums[i] SHALL be written 16'h0000 without a pop for every i >= fifo_count at LOAD entry.
REQ-023 SHALL enter SEND from LOAD, assert send_data=1 for exactly one cycle, then go to WAIT.
REQ-024 WAIT SHALL last at least one cycle and return to IDLE on the first edge with tx_ready=1.
REQ-025 SHALL hold tx_nums stable from the end of LOAD until the next LOAD.
REQ-026 Latency (N_TX_NUMS=1, tx_ready=1, empty FIFO): for a word accepted at edge k, send_data SHALL be high in the cycle after edge k+2.
REQ-027 Words arriving during LOAD, SEND or WAIT SHALL still be accepted and SHALL NOT disturb the batch in flight.

Reset
REQ-028 With reset=1 at a clock edge, the block SHALL set state=IDLE, FIFO pointers and fifo_count to 0, flush_pending=0, overflow=0, send_data=0 and all tx_nums=16'h0000; in_ready follows count and is 1.
REQ-029 Reset asserted mid-LOAD, mid-SEND or mid-WAIT SHALL abort the transfer, discard buffered words and emit no send_data pulse.

Verification
REQ-030 Single word: N=1, push 16'h55AA with tx_ready=1 -> tx_nums[0]=16'h55AA, one send_data pulse 3 cycles after acceptance, fifo_count returns to 0.
REQ-031 Batch plus flush: N=4, push 1,2,3,4,5 then flush -> first send has tx_nums={1,2,3,4}; second send has {5,0,0,0}; exactly two pulses.
REQ-032 Backpressure: tx_ready held 0, push 17 words with FIFO_DEPTH=16 -> in_ready falls after 16 words, overflow=1, fifo_count=16; after release, the 16 words are sent in order.
REQ-033 Busy uart: N=1, push 16'h0001 and 16'h0002 back-to-back, tx_ready held low for 100 cycles after the first send_data -> second send_data occurs only after tx_ready returns to 1.
REQ-034 Reset mid-operation: N=4, assert reset during LOAD cycle 2 -> no send_data, fifo_count=0, tx_nums all 0, overflow=0.
REQ-035 Simultaneous push/pop: N=2, push continuously at one word per cycle -> no word lost or duplicated, and the output sequence equals the input sequence.

Source files
------------

// File: rtl/uart_tx_batcher_if.sv
// ---------------------------------------------------------------------------
// uart_tx_batcher_if
//
// Bundles the producer handshake, the uart-facing batch bus and the status
// outputs of uart_tx_batcher into one interface.
//
//   Producer side : in_valid, in_num[15:0], in_ready, flush
//   Uart side     : tx_nums[N_TX_NUMS][16], send_data, tx_ready
//   Status        : fifo_count[$clog2(FIFO_DEPTH):0], overflow
//
// modport slave  - seen by the batcher (drives in_ready, tx_nums, send_data,
//                  fifo_count, overflow).
// modport master - seen by the environment (producer plus uart).
// ---------------------------------------------------------------------------
interface uart_tx_batcher_if #(
    parameter int N_TX_NUMS  = 1,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                        in_valid;
    logic [15:0]                 in_num;
    logic                        in_ready;
    logic                        flush;
    logic [N_TX_NUMS-1:0][15:0]  tx_nums;
    logic                        send_data;
    logic                        tx_ready;
    logic [CW-1:0]               fifo_count;
    logic                        overflow;

    modport master (
        output in_valid, in_num, flush, tx_ready,
        input  in_ready, tx_nums, send_data, fifo_count, overflow
    );

    modport slave (
        input  in_valid, in_num, flush, tx_ready,
        output in_ready, tx_nums, send_data, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_batcher.sv
// ---------------------------------------------------------------------------
// uart_tx_batcher
//
// Buffers 16-bit words from a producer in a FIFO and hands them to a uart
// transmitter in batches of N_TX_NUMS words.  A batch is launched when enough
// words are buffered, or earlier when a flush has been requested (missing
// words are then sent as zero).
//
// Ports
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - uart_tx_batcher_if.slave:
//              in_valid/in_num/in_ready : producer handshake
//              flush                    : one-cycle partial-batch request
//              tx_nums                  : batch presented to the uart
//              send_data                : one-cycle start strobe to the uart
//              tx_ready                 : uart idle
//              fifo_count               : words currently buffered
//              overflow                 : sticky, a write was dropped
//
// Parameters
//   N_TX_NUMS  - words per batch (must match the uart)
//   FIFO_DEPTH - FIFO capacity, power of two, >= 2 and >= N_TX_NUMS
//
// Transfer sequence: IDLE -> LOAD (N_TX_NUMS cycles, one word per cycle)
// -> SEND (send_data high) -> WAIT (until tx_ready) -> IDLE.
// ---------------------------------------------------------------------------
module uart_tx_batcher #(
    parameter int N_TX_NUMS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_batcher_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;   // count width (holds FIFO_DEPTH)
    localparam int PW = $clog2(FIFO_DEPTH);       // pointer width, wraps naturally

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] N_C     = CW'(N_TX_NUMS);
    localparam logic [CW-1:0] LAST_C  = CW'(N_TX_NUMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     state_reg;
    logic [CW-1:0]              load_idx_reg;    // word slot being filled in LOAD
    logic [CW-1:0]              load_avail_reg;  // words to pop in this LOAD
    logic                       flush_pending_reg;
    logic                       send_data_reg;

    logic [15:0]                mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_reg;
    logic [PW-1:0]              rd_ptr_reg;
    logic [CW-1:0]              count_reg;
    logic                       overflow_reg;

    logic [N_TX_NUMS-1:0][15:0] tx_nums_w;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        in_ready;
    logic        push;
    logic        pop;
    logic        start_load;
    logic [15:0] head;

    assign in_ready = (count_reg < DEPTH_C);
    assign push     = bus.in_valid && in_ready;

    // Only the words present when LOAD began are popped; slots beyond that
    // (flushed partial batch) are filled with zero instead.  Words pushed
    // during LOAD therefore stay in the FIFO for the next batch.
    assign pop      = (state_reg == LOAD) && (load_idx_reg < load_avail_reg);
    assign head     = mem[rd_ptr_reg];

    assign start_load = bus.tx_ready &&
                        ((count_reg >= N_C) ||
                         (flush_pending_reg && (count_reg != '0)));

    // ------------------------------------------------------------------
    // FIFO storage (no reset: contents are meaningless once pointers clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_num;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (bus.in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            load_idx_reg      <= '0;
            load_avail_reg    <= '0;
            flush_pending_reg <= 1'b0;
            send_data_reg     <= 1'b0;
        end else begin
            send_data_reg <= 1'b0;

            // A flush on an empty FIFO has nothing to send and is dropped.
            if (bus.flush && (count_reg != '0)) begin
                flush_pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start_load) begin
                        state_reg         <= LOAD;
                        load_idx_reg      <= '0;
                        load_avail_reg    <= (count_reg >= N_C) ? N_C : count_reg;
                        // Entering LOAD consumes the pending flush; a flush
                        // arriving on this same edge is covered by this batch.
                        flush_pending_reg <= 1'b0;
                    end
                end

                LOAD: begin
                    if (load_idx_reg == LAST_C) begin
                        state_reg     <= SEND;
                        send_data_reg <= 1'b1;
                    end else begin
                        load_idx_reg <= load_idx_reg + CW'(1);
                    end
                end

                SEND: begin
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (bus.tx_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Batch registers: slot gi is written only in LOAD cycle gi, so the
    // batch stays stable from the end of LOAD until the next LOAD.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_TX_NUMS; gi++) begin : g_word
        logic [15:0] word_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                word_reg <= 16'h0000;
            end else if ((state_reg == LOAD) && (load_idx_reg == CW'(gi))) begin
                word_reg <= pop ? head : 16'h0000;
            end
        end

        assign tx_nums_w[gi] = word_reg;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = in_ready;
    assign bus.tx_nums    = tx_nums_w;
    assign bus.send_data  = send_data_reg;
    assign bus.fifo_count = count_reg;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_batcher.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_batcher
//
// Three batcher instances (N_TX_NUMS = 1, 2 and 4, FIFO_DEPTH = 16) share one
// clock.  Directed sequences push the expected batch for every transfer into
// a per-instance queue; a monitor per instance pops and compares on every
// send_data pulse.
// ---------------------------------------------------------------------------
module tb_uart_tx_batcher;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst2, rst4;

    uart_tx_batcher_if #(.N_TX_NUMS(1), .FIFO_DEPTH(16)) bus1 ();
    uart_tx_batcher_if #(.N_TX_NUMS(2), .FIFO_DEPTH(16)) bus2 ();
    uart_tx_batcher_if #(.N_TX_NUMS(4), .FIFO_DEPTH(16)) bus4 ();

    uart_tx_batcher #(.N_TX_NUMS(1), .FIFO_DEPTH(16)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    uart_tx_batcher #(.N_TX_NUMS(2), .FIFO_DEPTH(16)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));
    uart_tx_batcher #(.N_TX_NUMS(4), .FIFO_DEPTH(16)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp1_q[$];
    logic [63:0] exp2_q[$];
    logic [63:0] exp4_q[$];
    int sends1 = 0;
    int sends2 = 0;
    int sends4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitors: one per instance, sampling on the falling edge
    // ------------------------------------------------------------------
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.send_data === 1'b1) begin
                sends1++;
                check("n1_pulse_width", 64'(prev), 64'd0);
                if (exp1_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n1_unexpected_send: got tx_nums %h, expected no send", bus1.tx_nums);
                end else begin
                    check("n1_batch", 64'(bus1.tx_nums), exp1_q.pop_front());
                end
            end
            prev = bus1.send_data;
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.send_data === 1'b1) begin
                sends2++;
                check("n2_pulse_width", 64'(prev), 64'd0);
                if (exp2_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n2_unexpected_send: got tx_nums %h, expected no send", bus2.tx_nums);
                end else begin
                    check("n2_batch", 64'(bus2.tx_nums), exp2_q.pop_front());
                end
            end
            prev = bus2.send_data;
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus4.send_data === 1'b1) begin
                sends4++;
                check("n4_pulse_width", 64'(prev), 64'd0);
                if (exp4_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL n4_unexpected_send: got tx_nums %h, expected no send", bus4.tx_nums);
                end else begin
                    check("n4_batch", 64'(bus4.tx_nums), exp4_q.pop_front());
                end
            end
            prev = bus4.send_data;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int seen;
        int s0;

        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_num = '0; bus1.flush = 1'b0; bus1.tx_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_num = '0; bus2.flush = 1'b0; bus2.tx_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_num = '0; bus4.flush = 1'b0; bus4.tx_ready = 1'b1;
        repeat (3) tick();
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

        // ---------------- reset state ----------------
        check("rst_n1_in_ready",  64'(bus1.in_ready),   64'd1);
        check("rst_n1_count",     64'(bus1.fifo_count), 64'd0);
        check("rst_n1_overflow",  64'(bus1.overflow),   64'd0);
        check("rst_n1_send",      64'(bus1.send_data),  64'd0);
        check("rst_n1_tx_nums",   64'(bus1.tx_nums),    64'd0);
        check("rst_n2_in_ready",  64'(bus2.in_ready),   64'd1);
        check("rst_n2_count",     64'(bus2.fifo_count), 64'd0);
        check("rst_n2_tx_nums",   64'(bus2.tx_nums),    64'd0);
        check("rst_n4_in_ready",  64'(bus4.in_ready),   64'd1);
        check("rst_n4_count",     64'(bus4.fifo_count), 64'd0);
        check("rst_n4_overflow",  64'(bus4.overflow),   64'd0);
        check("rst_n4_tx_nums",   64'(bus4.tx_nums),    64'd0);

        // ---------------- N=1 single word, latency ----------------
        bus1.in_valid = 1'b1; bus1.in_num = 16'h55AA;
        exp1_q.push_back(64'h55AA);
        tick();                                 // edge k: accepted
        bus1.in_valid = 1'b0;
        check("n1_single_count_k",  64'(bus1.fifo_count), 64'd1);
        check("n1_single_send_k",   64'(bus1.send_data),  64'd0);
        tick();                                 // edge k+1: IDLE -> LOAD
        check("n1_single_send_k1",  64'(bus1.send_data),  64'd0);
        tick();                                 // edge k+2: LOAD -> SEND
        check("n1_single_send_k2",  64'(bus1.send_data),  64'd1);
        check("n1_single_tx",       64'(bus1.tx_nums),    64'h55AA);
        check("n1_single_count_k2", 64'(bus1.fifo_count), 64'd0);
        tick();
        check("n1_single_send_k3",  64'(bus1.send_data),  64'd0);
        repeat (3) tick();

        // ---------------- N=1 busy uart ----------------
        bus1.in_valid = 1'b1; bus1.in_num = 16'h0001; exp1_q.push_back(64'h0001);
        tick();
        bus1.in_num = 16'h0002; exp1_q.push_back(64'h0002);
        tick();
        bus1.in_valid = 1'b0;
        n = 0;
        while (bus1.send_data !== 1'b1 && n < 10) begin tick(); n++; end
        check("n1_busy_first_send", 64'(bus1.send_data), 64'd1);
        bus1.tx_ready = 1'b0;
        seen = 0;
        repeat (100) begin
            tick();
            if (bus1.send_data === 1'b1) seen++;
        end
        check("n1_busy_hold_sends", 64'(seen), 64'd0);
        check("n1_busy_hold_count", 64'(bus1.fifo_count), 64'd1);
        bus1.tx_ready = 1'b1;
        n = 0;
        while (bus1.send_data !== 1'b1 && n < 10) begin tick(); n++; end
        check("n1_busy_second_send", 64'(bus1.send_data), 64'd1);
        repeat (3) tick();
        check("n1_busy_drained", 64'(exp1_q.size()), 64'd0);

        // ---------------- N=1 backpressure / overflow ----------------
        bus1.tx_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_num   = 16'(16'h0100 + i);
            check($sformatf("n1_bp_in_ready_%0d", i), 64'(bus1.in_ready), (i < 16) ? 64'd1 : 64'd0);
            if (i < 16) exp1_q.push_back(64'(16'h0100 + i));
            tick();
        end
        bus1.in_valid = 1'b0;
        check("n1_bp_overflow", 64'(bus1.overflow),   64'd1);
        check("n1_bp_count",    64'(bus1.fifo_count), 64'd16);
        check("n1_bp_in_ready", 64'(bus1.in_ready),   64'd0);
        bus1.tx_ready = 1'b1;
        n = 0;
        while (exp1_q.size() != 0 && n < 200) begin tick(); n++; end
        repeat (3) tick();
        check("n1_bp_drained",        64'(exp1_q.size()),   64'd0);
        check("n1_bp_count_after",    64'(bus1.fifo_count), 64'd0);
        check("n1_bp_overflow_stick", 64'(bus1.overflow),   64'd1);

        // ---------------- N=4 batch plus flush ----------------
        s0 = sends4;
        exp4_q.push_back(64'h0004_0003_0002_0001);
        exp4_q.push_back(64'h0000_0000_0000_0005);
        for (int i = 1; i <= 5; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_num   = 16'(i);
            tick();
        end
        bus4.in_valid = 1'b0;
        bus4.flush    = 1'b1;
        tick();
        bus4.flush    = 1'b0;
        repeat (30) tick();
        check("n4_flush_pulses",  64'(sends4 - s0),     64'd2);
        check("n4_flush_drained", 64'(exp4_q.size()),   64'd0);
        check("n4_flush_count",   64'(bus4.fifo_count), 64'd0);

        // ---------------- N=4 reset during LOAD cycle 2 ----------------
        s0 = sends4;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_num   = 16'(16'h000A + i);
            tick();
        end
        bus4.in_valid = 1'b0;
        tick();                                 // IDLE -> LOAD
        tick();                                 // slot 0 written
        tick();                                 // slot 1 written, now in LOAD cycle 2
        check("n4_rst_partial_tx", 64'(bus4.tx_nums),    64'h0000_0000_000B_000A);
        check("n4_rst_partial_ct", 64'(bus4.fifo_count), 64'd2);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("n4_rst_count",    64'(bus4.fifo_count), 64'd0);
        check("n4_rst_tx_nums",  64'(bus4.tx_nums),    64'd0);
        check("n4_rst_overflow", 64'(bus4.overflow),   64'd0);
        check("n4_rst_in_ready", 64'(bus4.in_ready),   64'd1);
        repeat (20) tick();
        check("n4_rst_no_send",  64'(sends4 - s0),     64'd0);

        // ---------------- N=2 flush on empty FIFO is ignored ----------------
        bus2.flush = 1'b1;
        tick();
        bus2.flush = 1'b0;
        repeat (10) tick();
        check("n2_empty_flush", 64'(sends2), 64'd0);

        // ---------------- N=2 continuous push with overlapping pops ----------------
        for (int i = 0; i < 20; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_num   = 16'(200 + i);
            check($sformatf("n2_stream_in_ready_%0d", i), 64'(bus2.in_ready), 64'd1);
            if (i % 2 == 1) exp2_q.push_back({32'h0, 16'(200 + i), 16'(199 + i)});
            tick();
        end
        bus2.in_valid = 1'b0;
        n = 0;
        while (exp2_q.size() != 0 && n < 300) begin tick(); n++; end
        repeat (5) tick();
        check("n2_stream_drained",  64'(exp2_q.size()),   64'd0);
        check("n2_stream_sends",    64'(sends2),          64'd10);
        check("n2_stream_count",    64'(bus2.fifo_count), 64'd0);
        check("n2_stream_overflow", 64'(bus2.overflow),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
